// File: rtl/countdown_timer_tc.sv
// Programmable down-counting timer driven by an upstream terminal-count tick.
// Optional build macro COUNTDOWN_AUTO_RELOAD_EN: periodic reload of P on expiry instead of stopping.
module countdown_timer_tc #(
   parameter int WIDTH = 24
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             CLK_ENA,
   input  logic             LOADn,
   input  logic [WIDTH-1:0] P,
   input  logic             START,
   input  logic             STOP,
   output logic [WIDTH-1:0] Q,
   output logic             TC,
   output logic             DONE,
   output logic             BUSY,
   output logic [1:0]       STATE
);

   typedef enum logic [1:0] {
      IDLE    = 2'b00,
      RUN     = 2'b01,
      PAUSE   = 2'b10,
      EXPIRED = 2'b11
   } state_t;

   localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);
   localparam logic [WIDTH-1:0] ZERO = '0;

   state_t           state_reg, state_next;
   logic [WIDTH-1:0] q_reg, q_next;
   logic             done_reg, done_next;

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_reg <= IDLE;
         q_reg     <= ZERO;
         done_reg  <= 1'b0;
      end else begin
         state_reg <= state_next;
         q_reg     <= q_next;
         done_reg  <= done_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      q_next     = q_reg;
      done_next  = 1'b0;
      if (!LOADn) begin
         q_next     = P;
         state_next = IDLE;
      end else begin
         case (state_reg)
            IDLE: begin
               // STOP outranks START, so a simultaneous press never starts the count
               if (!STOP && START && (q_reg != ZERO))
                  state_next = RUN;
            end
            RUN: begin
               if (STOP) begin
                  state_next = PAUSE;
               end else if (CLK_ENA) begin
                  if (q_reg > ONE) begin
                     q_next = q_reg - ONE;
                  end else if (q_reg == ONE) begin
                     done_next = 1'b1;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
                     q_next = P;
                     if (P == ZERO)
                        state_next = EXPIRED;
`else
                     q_next     = ZERO;
                     state_next = EXPIRED;
`endif
                  end else begin
                     // Q==0 while running cannot arise normally; park safely
                     state_next = EXPIRED;
                  end
               end
            end
            PAUSE: begin
               if (START && !STOP)
                  state_next = RUN;
            end
            EXPIRED: begin
               q_next = ZERO;
            end
            default: begin
               state_next = IDLE;
            end
         endcase
      end
   end

   assign TC    = (state_reg == RUN) && (q_reg == ONE) && CLK_ENA && LOADn && !STOP;
   assign Q     = q_reg;
   assign DONE  = done_reg;
   assign STATE = state_reg;
   assign BUSY  = (state_reg == RUN) || (state_reg == PAUSE);

endmodule

// File: tb/tb_countdown_timer_tc.sv
// Directed self-checking bench for countdown_timer_tc at WIDTH=4.
module tb_countdown_timer_tc;

   localparam int W = 4;

   logic         CLK = 1'b0;
   logic         RST = 1'b1;
   logic         CLK_ENA = 1'b0;
   logic         LOADn = 1'b1;
   logic [W-1:0] P = '0;
   logic         START = 1'b0;
   logic         STOP = 1'b0;
   logic [W-1:0] Q;
   logic         TC;
   logic         DONE;
   logic         BUSY;
   logic [1:0]   STATE;

   int n_checks = 0;
   int n_pass   = 0;

   countdown_timer_tc #(.WIDTH(W)) dut (
      .CLK    (CLK),
      .RST    (RST),
      .CLK_ENA(CLK_ENA),
      .LOADn  (LOADn),
      .P      (P),
      .START  (START),
      .STOP   (STOP),
      .Q      (Q),
      .TC     (TC),
      .DONE   (DONE),
      .BUSY   (BUSY),
      .STATE  (STATE)
   );

   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) begin
         n_pass++;
         $display("ok   %s = %0d", tag, obs);
      end else begin
         $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic load(input logic [W-1:0] pv);
      LOADn = 1'b0;
      P     = pv;
      step();
      LOADn = 1'b1;
   endtask

   logic [W-1:0] exp_q [6];
   logic [1:0]   exp_final_state;
   int           exp_done_cnt;
   int           done_cnt;

   initial begin
`ifdef COUNTDOWN_AUTO_RELOAD_EN
      exp_q = '{4'd1, 4'd2, 4'd1, 4'd2, 4'd1, 4'd2};
      exp_final_state = 2'b01;
      exp_done_cnt    = 3;
`else
      exp_q = '{4'd1, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0};
      exp_final_state = 2'b11;
      exp_done_cnt    = 1;
`endif

      // Reset state
      #1;
      check("rst_q", Q, 0);
      check("rst_state", STATE, 2'b00);
      check("rst_done", DONE, 0);
      check("rst_busy", BUSY, 0);
      #12 RST = 1'b0;

      // Start edge never decrements; then asynchronous reset mid-run
      load(4'd7);
      check("load7_q", Q, 7);
      START = 1'b1; CLK_ENA = 1'b1;
      step();
      START = 1'b0; CLK_ENA = 1'b0;
      check("start_nodec_q", Q, 7);
      check("start_state", STATE, 2'b01);
      #2 RST = 1'b1;
      #1;
      check("async_rst_q", Q, 0);
      check("async_rst_state", STATE, 2'b00);
      check("async_rst_done", DONE, 0);
      check("async_rst_busy", BUSY, 0);
      #1 RST = 1'b0;

      // Count 3 -> 0 with TC on the last tick and DONE one cycle later
      load(4'd3);
      START = 1'b1;
      step();
      START = 1'b0;
      check("run3_q", Q, 3);
      CLK_ENA = 1'b1;
      step();
      check("tick1_q", Q, 2);
      check("tick1_tc", TC, 0);
      step();
      check("tick2_q", Q, 1);
      check("tick3_tc", TC, 1);
      step();
      check("tick3_q", Q, 0);
      check("tick3_state", STATE, 2'b11);
      check("tick3_done", DONE, 1);
      check("expired_tc", TC, 0);
      CLK_ENA = 1'b0;
      step();
      check("done_pulse_end", DONE, 0);
      START = 1'b1; CLK_ENA = 1'b1;
      step();
      START = 1'b0; CLK_ENA = 1'b0;
      check("expired_start_q", Q, 0);
      check("expired_start_state", STATE, 2'b11);

      // Pause holds the count while ticks keep arriving
      load(4'd7);
      START = 1'b1;
      step();
      START = 1'b0; CLK_ENA = 1'b1;
      step();
      step();
      check("pre_pause_q", Q, 5);
      STOP = 1'b1;
      for (int i = 0; i < 4; i++) step();
      check("pause_q", Q, 5);
      check("pause_state", STATE, 2'b10);
      check("pause_busy", BUSY, 1);
      STOP = 1'b0; START = 1'b1; CLK_ENA = 1'b0;
      step();
      check("resume_state", STATE, 2'b01);
      START = 1'b0; CLK_ENA = 1'b1;
      step();
      CLK_ENA = 1'b0;
      check("resume_tick_q", Q, 4);

      // START+STOP priority and load over start
      load(4'd2);
      START = 1'b1; STOP = 1'b1;
      step();
      check("idle_both_state", STATE, 2'b00);
      check("idle_both_q", Q, 2);
      STOP = 1'b0;
      step();
      check("run_state", STATE, 2'b01);
      STOP = 1'b1;
      step();
      check("run_both_state", STATE, 2'b10);
      STOP = 1'b0; LOADn = 1'b0; P = 4'd9;
      step();
      LOADn = 1'b1; START = 1'b0;
      check("load_start_q", Q, 9);
      check("load_start_state", STATE, 2'b00);

      // Zero preset never starts
      load(4'd0);
      START = 1'b1; CLK_ENA = 1'b1;
      #1;
      check("p0_tc", TC, 0);
      step();
      check("p0_state", STATE, 2'b00);
      check("p0_done", DONE, 0);
      START = 1'b0; CLK_ENA = 1'b0;

      // Six ticks from P=2: expiry or periodic reload depending on build
      load(4'd2);
      START = 1'b1;
      step();
      START = 1'b0; CLK_ENA = 1'b1;
      done_cnt = 0;
      for (int i = 0; i < 6; i++) begin
         step();
         check($sformatf("p2_tick%0d_q", i + 1), Q, exp_q[i]);
         if (DONE) done_cnt++;
      end
      CLK_ENA = 1'b0;
      check("p2_done_count", done_cnt, exp_done_cnt);
      check("p2_final_state", STATE, exp_final_state);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
